ikaopll_mixer: RTL and testbench
================================

// Module: ikaopll_mixer
// PURPOSE
//  Multi-chip output mixer downstream of one or more IKAOPLL cores. Integrates each core's
//  time-multiplexed 10-bit MO/RO sample strobes over one output frame, applies rhythm gain and
//  per-chip L/R panning, sums the cores serially and emits one saturated stereo sample per frame.
// PARAMETERS
//  NUM_CHIPS    2   number of OPLL cores mixed (1..8)
//  MAX_SAMPLES  16  samples per frame per stream before accumulator saturation (power of 2)
//  RO_SHIFT     1   left shift applied to rhythm (RO) accumulator before mixing
//  OUT_SHIFT    2   left shift applied to final sum before saturation
//  OUT_WIDTH    16  signed output sample width
// PORTS
//  i_EMUCLK      in   1               master clock
//  i_RST         in   1               reset: synchronous, active-high
//  i_FRAME_SYNC  in   1               one-cycle pulse, closes current frame
//  i_MO_SAMPLE   in   NUM_CHIPS       per-chip MO sample strobe
//  i_RO_SAMPLE   in   NUM_CHIPS       per-chip RO sample strobe
//  i_MO          in   NUM_CHIPS*10    packed signed MO, chip k at [10k+9:10k]
//  i_RO          in   NUM_CHIPS*10    packed signed RO, same packing
//  i_PAN         in   NUM_CHIPS*2     per chip {L_en,R_en}
//  i_CLR_OVR     in   1               clears o_OVERRUN
//  o_L, o_R      out  OUT_WIDTH       signed mixed output, held until next o_VALID
//  o_VALID       out  1               one-cycle pulse when o_L/o_R update
//  o_BUSY        out  1               high in SUM and OUT states
//  o_OVERRUN     out  1               sticky: frame sync arrived while busy
// BEHAVIOUR
//  - Reset: o_L=o_R=0, o_VALID=0, o_BUSY=0, o_OVERRUN=0, all accumulators/shadows 0, state IDLE.
//    Reset mid-SUM/OUT aborts; no o_VALID issued.
//  - Accumulators: ACC_W = 10+clog2(MAX_SAMPLES) signed, one MO and one RO per chip; on strobe
//    acc += sample, saturating at signed ACC_W limits (no wrap).
//  - FSM IDLE -> SUM -> OUT -> IDLE.
//    IDLE + i_FRAME_SYNC: copy all accumulators to shadow (a same-cycle strobe IS included in the
//    closing frame), clear live accumulators to 0, idx=0, sumL=sumR=0, go SUM.
//    SUM: one chip per cycle: c = shadowMO[idx] + (shadowRO[idx] <<< RO_SHIFT);
//    sumL += L_en ? c : 0; sumR += R_en ? c : 0 (i_PAN sampled live during SUM);
//    after idx==NUM_CHIPS-1 go OUT.
//    OUT: o_L/o_R = saturate(sum <<< OUT_SHIFT) to OUT_WIDTH signed; o_VALID=1 this cycle; IDLE.
//  - Latency: sync at cycle t -> o_VALID at t+NUM_CHIPS+1.
//  - Sum width: ACC_W+RO_SHIFT+clog2(NUM_CHIPS)+2 signed, sized so no internal wrap occurs.
//  - i_FRAME_SYNC while o_BUSY: ignored for snapshot, live accumulators NOT cleared (frame
//    merges into next), o_OVERRUN<=1; in-flight frame completes normally.
//  - o_OVERRUN: set has priority over simultaneous i_CLR_OVR.
//  - Strobes continue accumulating into live registers in all states.
// STRUCTURE
//  - ikaopll_pkg: IKAOPLL_SAMPLE_W=10, mixer state enum (IDLE/SUM/OUT), sat/clog2 functions.
//  - Sub-module ikaopll_mixer_acc: one chip's saturating MO/RO accumulator pair with
//    snapshot-and-clear; instantiated NUM_CHIPS times via generate.
//  - Top: FSM, chip index counter, serial adder, output saturation/registers.
// TESTING (NUM_CHIPS=2, defaults)
//  1 chip0 MO=100 x3, PAN0=11, sync at t -> o_VALID at t+3, o_L=o_R=1200.
//  2 chip1 RO=-50 x2, PAN1=10, chip0 idle -> o_L=-800, o_R=0.
//  3 both chips MO=511 x16 and RO=511 x16, PAN=11 -> sum 196224, o_L=o_R=32767; separately
//    chip0 MO=-512 x20 -> acc clamps -8192, o_L=-32768.
//  4 second sync 1 cycle after first -> o_OVERRUN=1, first frame output correct, samples
//    between both syncs appear in following frame; i_CLR_OVR -> 0.
//  5 chip0 MO=7 strobe same cycle as sync -> 7 in closing frame (o_L=28), next frame 0.
//  6 i_RST asserted during SUM -> no o_VALID, o_L=o_R=0, next frame mixes correctly.

Source files
------------

// File: rtl/ikaopll_pkg.sv
// Shared definitions for the IKAOPLL multi-chip output mixer.
package ikaopll_pkg;

  localparam int IKAOPLL_SAMPLE_W = 10;

  typedef enum logic [1:0] {
    MIX_IDLE = 2'd0,
    MIX_SUM  = 2'd1,
    MIX_OUT  = 2'd2
  } mix_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic longint sat_s(input longint v, input int unsigned w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ikaopll_mixer_acc.sv
// One chip's saturating MO/RO frame accumulators with snapshot-and-clear into shadow registers.
module ikaopll_mixer_acc
  import ikaopll_pkg::*;
#(
  parameter int ACC_W = 14
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               snap,
  input  logic                               mo_stb,
  input  logic                               ro_stb,
  input  logic signed [IKAOPLL_SAMPLE_W-1:0] mo,
  input  logic signed [IKAOPLL_SAMPLE_W-1:0] ro,
  output logic signed [ACC_W-1:0]            mo_shadow,
  output logic signed [ACC_W-1:0]            ro_shadow
);

  logic signed [ACC_W-1:0] mo_acc, ro_acc;
  logic signed [ACC_W-1:0] mo_next, ro_next;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]            a,
    input logic signed [IKAOPLL_SAMPLE_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = (ACC_W + 1)'(a) + (ACC_W + 1)'(b);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  always_comb begin
    mo_next = mo_stb ? sat_add(mo_acc, mo) : mo_acc;
    ro_next = ro_stb ? sat_add(ro_acc, ro) : ro_acc;
  end

  // A strobe landing on the snapshot cycle belongs to the frame being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      mo_acc    <= '0;
      ro_acc    <= '0;
      mo_shadow <= '0;
      ro_shadow <= '0;
    end else if (snap) begin
      mo_shadow <= mo_next;
      ro_shadow <= ro_next;
      mo_acc    <= '0;
      ro_acc    <= '0;
    end else begin
      mo_acc <= mo_next;
      ro_acc <= ro_next;
    end
  end

endmodule

// File: rtl/ikaopll_mixer.sv
// Multi-chip OPLL mixer: per-frame integration, rhythm gain, panning, serial sum, saturated stereo out.
module ikaopll_mixer
  import ikaopll_pkg::*;
#(
  parameter int NUM_CHIPS   = 2,
  parameter int MAX_SAMPLES = 16,
  parameter int RO_SHIFT    = 1,
  parameter int OUT_SHIFT   = 2,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                                  i_EMUCLK,
  input  logic                                  i_RST,
  input  logic                                  i_FRAME_SYNC,
  input  logic [NUM_CHIPS-1:0]                  i_MO_SAMPLE,
  input  logic [NUM_CHIPS-1:0]                  i_RO_SAMPLE,
  input  logic [NUM_CHIPS*IKAOPLL_SAMPLE_W-1:0] i_MO,
  input  logic [NUM_CHIPS*IKAOPLL_SAMPLE_W-1:0] i_RO,
  input  logic [NUM_CHIPS*2-1:0]                i_PAN,
  input  logic                                  i_CLR_OVR,
  output logic signed [OUT_WIDTH-1:0]           o_L,
  output logic signed [OUT_WIDTH-1:0]           o_R,
  output logic                                  o_VALID,
  output logic                                  o_BUSY,
  output logic                                  o_OVERRUN
);

  localparam int ACC_W = IKAOPLL_SAMPLE_W + int'(clog2(MAX_SAMPLES));
  localparam int SUM_W = ACC_W + RO_SHIFT + int'(clog2(NUM_CHIPS)) + 2;
  localparam int SHL_W = SUM_W + OUT_SHIFT;
  localparam int IDX_W = (NUM_CHIPS > 1) ? int'(clog2(NUM_CHIPS)) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHIPS - 1);

  mix_state_e              state;
  logic [IDX_W-1:0]        idx;
  logic signed [SUM_W-1:0] sum_l, sum_r;
  logic signed [SUM_W-1:0] chip_sum;
  logic signed [SHL_W-1:0] shl_l, shl_r;
  logic [1:0]              pan_sel;
  logic                    snap;
  logic signed [ACC_W-1:0] mo_sh [NUM_CHIPS];
  logic signed [ACC_W-1:0] ro_sh [NUM_CHIPS];

  assign snap   = (state == MIX_IDLE) && i_FRAME_SYNC;
  assign o_BUSY = (state != MIX_IDLE);

  for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_chip
    ikaopll_mixer_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .clk       (i_EMUCLK),
      .rst       (i_RST),
      .snap      (snap),
      .mo_stb    (i_MO_SAMPLE[k]),
      .ro_stb    (i_RO_SAMPLE[k]),
      .mo        (i_MO[IKAOPLL_SAMPLE_W*k +: IKAOPLL_SAMPLE_W]),
      .ro        (i_RO[IKAOPLL_SAMPLE_W*k +: IKAOPLL_SAMPLE_W]),
      .mo_shadow (mo_sh[k]),
      .ro_shadow (ro_sh[k])
    );
  end

  always_comb begin
    chip_sum = SUM_W'(mo_sh[idx]) + (SUM_W'(ro_sh[idx]) <<< RO_SHIFT);
    pan_sel  = i_PAN[2*idx +: 2];
    shl_l    = SHL_W'(sum_l) <<< OUT_SHIFT;
    shl_r    = SHL_W'(sum_r) <<< OUT_SHIFT;
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state     <= MIX_IDLE;
      idx       <= '0;
      sum_l     <= '0;
      sum_r     <= '0;
      o_L       <= '0;
      o_R       <= '0;
      o_VALID   <= 1'b0;
      o_OVERRUN <= 1'b0;
    end else begin
      o_VALID <= 1'b0;
      // A sync while busy is dropped; its samples roll into the next frame.
      if (i_FRAME_SYNC && state != MIX_IDLE) o_OVERRUN <= 1'b1;
      else if (i_CLR_OVR)                    o_OVERRUN <= 1'b0;

      case (state)
        MIX_IDLE: begin
          if (i_FRAME_SYNC) begin
            idx   <= '0;
            sum_l <= '0;
            sum_r <= '0;
            state <= MIX_SUM;
          end
        end
        MIX_SUM: begin
          sum_l <= sum_l + (pan_sel[1] ? chip_sum : '0);
          sum_r <= sum_r + (pan_sel[0] ? chip_sum : '0);
          if (idx == LAST_IDX) state <= MIX_OUT;
          else                 idx   <= idx + IDX_W'(1);
        end
        MIX_OUT: begin
          o_L     <= OUT_WIDTH'(sat_s(64'(shl_l), OUT_WIDTH));
          o_R     <= OUT_WIDTH'(sat_s(64'(shl_r), OUT_WIDTH));
          o_VALID <= 1'b1;
          state   <= MIX_IDLE;
        end
        default: state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ikaopll_mixer.sv
// Scoreboard bench for ikaopll_mixer: frame-level reference model, directed cases then random traffic.
module tb_ikaopll_mixer;

  localparam int N       = 2;
  localparam int RO_SH   = 1;
  localparam int OUT_SH  = 2;
  localparam int OW      = 16;
  localparam longint ACC_HI = 8191;
  localparam longint ACC_LO = -8192;
  localparam longint OUT_HI = 32767;
  localparam longint OUT_LO = -32768;

  logic              clk = 1'b0;
  logic              rst, sync, clr;
  logic [N-1:0]      mo_stb, ro_stb;
  logic [N*10-1:0]   mo, ro;
  logic [N*2-1:0]    pan;
  logic signed [OW-1:0] o_l, o_r;
  logic              valid, busy, ovr;

  ikaopll_mixer #(
    .NUM_CHIPS   (N),
    .MAX_SAMPLES (16),
    .RO_SHIFT    (RO_SH),
    .OUT_SHIFT   (OUT_SH),
    .OUT_WIDTH   (OW)
  ) dut (
    .i_EMUCLK     (clk),
    .i_RST        (rst),
    .i_FRAME_SYNC (sync),
    .i_MO_SAMPLE  (mo_stb),
    .i_RO_SAMPLE  (ro_stb),
    .i_MO         (mo),
    .i_RO         (ro),
    .i_PAN        (pan),
    .i_CLR_OVR    (clr),
    .o_L          (o_l),
    .o_R          (o_r),
    .o_VALID      (valid),
    .o_BUSY       (busy),
    .o_OVERRUN    (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    longint l;
    longint r;
    int     at;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint last_l = 0, last_r = 0;

  // Reference model state: live frame integrals and frame-engine occupancy.
  longint live_mo[N], live_ro[N];
  bit     m_ovr;
  bit     have_frame;
  int     busy_until;

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out_L", o_l, e.l);
        check("out_R", o_r, e.r);
        check("latency", cyc, e.at);
        last_l = o_l;
        last_r = o_r;
      end
    end
  end

  task automatic step(input bit s, input bit [N-1:0] ms, input bit [N-1:0] rs,
                      input int m0, input int m1, input int r0, input int r1, input bit c);
    int     e;
    bit     accept;
    longint nm[N], nr[N];
    longint sl, sr, contrib;
    int     mv[N], rv[N];
    mv[0] = m0; mv[1] = m1; rv[0] = r0; rv[1] = r1;
    sync   = s;
    mo_stb = ms;
    ro_stb = rs;
    mo     = {10'(m1), 10'(m0)};
    ro     = {10'(r1), 10'(r0)};
    clr    = c;
    e      = cyc + 1;
    accept = s && !(have_frame && e <= busy_until);
    for (int k = 0; k < N; k++) begin
      nm[k] = clampv(live_mo[k] + (ms[k] ? longint'(mv[k]) : 0), ACC_LO, ACC_HI);
      nr[k] = clampv(live_ro[k] + (rs[k] ? longint'(rv[k]) : 0), ACC_LO, ACC_HI);
    end
    if (accept) begin
      sl = 0;
      sr = 0;
      for (int k = 0; k < N; k++) begin
        contrib = nm[k] + nr[k] * (64'sd1 <<< RO_SH);
        if (pan[2*k+1]) sl += contrib;
        if (pan[2*k])   sr += contrib;
        live_mo[k] = 0;
        live_ro[k] = 0;
      end
      sb.push_back('{clampv(sl * (64'sd1 <<< OUT_SH), OUT_LO, OUT_HI),
                     clampv(sr * (64'sd1 <<< OUT_SH), OUT_LO, OUT_HI), e + N + 1});
      busy_until = e + N + 1;
      have_frame = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        live_mo[k] = nm[k];
        live_ro[k] = nr[k];
      end
    end
    if (s && !accept) m_ovr = 1'b1;
    else if (c)       m_ovr = 1'b0;
    @(posedge clk);
    #1;
    sync   = 1'b0;
    mo_stb = '0;
    ro_stb = '0;
    clr    = 1'b0;
    check("overrun", ovr, m_ovr);
    check("busy", busy, (have_frame && e <= busy_until - 1) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    for (int k = 0; k < N; k++) begin
      live_mo[k] = 0;
      live_ro[k] = 0;
    end
    m_ovr      = 1'b0;
    have_frame = 1'b0;
    busy_until = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_L", o_l, 0);
    check("rst_R", o_r, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", ovr, 0);
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; clr = 1'b0;
    mo_stb = '0; ro_stb = '0; mo = '0; ro = '0; pan = '0;
    do_reset(3);

    // 1: chip0 MO=100 x3, both channels
    pan = 4'b0011;
    repeat (3) step(0, 2'b01, 2'b00, 100, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t1_L", last_l, 1200);
    check("t1_R", last_r, 1200);

    // 2: chip1 RO=-50 x2, left only
    pan = 4'b1000;
    repeat (2) step(0, 2'b00, 2'b10, 0, 0, 0, -50, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t2_L", last_l, -800);
    check("t2_R", last_r, 0);

    // 3: positive clip through both chips, then negative accumulator clamp
    pan = 4'b1111;
    repeat (16) step(0, 2'b11, 2'b11, 511, 511, 511, 511, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t3_pos_L", last_l, 32767);
    check("t3_pos_R", last_r, 32767);
    pan = 4'b0011;
    repeat (20) step(0, 2'b01, 2'b00, -512, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t3_neg_L", last_l, -32768);

    // 4: back-to-back sync gives overrun; second sync's samples roll over
    step(0, 2'b01, 2'b00, 5, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    step(1, 2'b01, 2'b00, 9, 0, 0, 0, 0);
    check("t4_ovr_set", ovr, 1);
    drain();
    check("t4_first_L", last_l, 20);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t4_next_L", last_l, 36);
    step(0, '0, '0, 0, 0, 0, 0, 1);
    check("t4_ovr_clr", ovr, 0);

    // 5: strobe coincident with sync lands in the closing frame
    step(1, 2'b01, 2'b00, 7, 0, 0, 0, 0);
    drain();
    check("t5_L", last_l, 28);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t5_next_L", last_l, 0);

    // 6: reset while summing aborts the frame
    step(0, 2'b01, 2'b00, 3, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    idle(1);
    do_reset(1);
    idle(6);
    step(0, 2'b01, 2'b00, 4, 0, 0, 0, 0);
    step(1, '0, '0, 0, 0, 0, 0, 0);
    drain();
    check("t6_L", last_l, 16);

    // Random traffic: pan only changes while the frame engine is idle
    for (int i = 0; i < 600; i++) begin
      bit s;
      s = ($urandom_range(0, 9) == 0);
      if (!s && !(have_frame && cyc + 1 <= busy_until) && $urandom_range(0, 5) == 0)
        pan = 4'($urandom);
      if ($urandom_range(0, 3) == 0)
        step(s, 2'($urandom), 2'($urandom), 511, -512, -512, 511,
             $urandom_range(0, 15) == 0);
      else
        step(s, 2'($urandom), 2'($urandom),
             int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
             int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
             $urandom_range(0, 15) == 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
